tbec_ecc_mem: RTL and testbench
===============================

Name: tbec_ecc_mem

Overview:
- 256-word by 16-bit synchronous storage array protected by an extended Hamming SEC-DED code (22-bit codeword).
- Data is encoded on write and stored as a codeword. On read it is decoded, single errors are corrected, and a 2-bit error status is reported.
- Sits between a simple address/data/write-enable master and the datapath.
- Includes an error-injection mask so verification can corrupt stored codewords.

Parameters:
- ADDR_W, 8, address width (depth = 2**ADDR_W = 256)
- DATA_W, 16, data word width
- CW_W, 22, codeword width (fixed for DATA_W=16: 16 data + 5 Hamming + 1 overall parity)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tbec_addr  input  8  word address for read or write
- data_in  input  16  write data
- mem_we  input  1  1 = write this cycle, 0 = read
- err_inject_mask  input  22  XOR mask applied to the codeword as it is written; bit i flips codeword position i; tie to 0 in normal use
- data_out  output  16  registered, decoded (corrected) read data
- out_error_code  output  2  registered status: 00 none, 01 data bit corrected, 10 uncorrectable (double), 11 check bit error corrected

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at posedge):
  - all 256 codewords cleared to 22'h0 (the valid encoding of 16'h0000)
  - data_out = 16'h0000, out_error_code = 2'b00
  - rst has priority over mem_we
- Codeword layout, positions 0..21:
  - Position 0 = overall parity.
  - Hamming parity p0..p4 at positions 1, 2, 4, 8, 16.
  - Data d0..d15 in ascending order at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21.
  - p_k (position 2^k) = XOR of all data positions whose index has bit k set (even parity).
  - Position 0 = XOR of positions 1..21.
- Write (mem_we=1 at posedge): mem[tbec_addr] <= encode(data_in) XOR err_inject_mask. data_out and out_error_code hold their previous values.
- Read (mem_we=0 at posedge): decode mem[tbec_addr] combinationally and register the result into data_out / out_error_code. Latency is 1 clock; the output is valid after the edge on which the address was sampled. Continuous back-to-back reads are allowed, one per cycle.
- Decode:
  - s[4:0] = XOR of the indices of all set bits among positions 1..21.
  - q = XOR of all 22 bits.
  - s==0, q==0: data unchanged, code 00.
  - q==1, s==0: overall parity bit in error; data unchanged, code 11.
  - q==1, s a power of two (1, 2, 4, 8, 16): Hamming check bit in error; data unchanged, code 11.
  - q==1, s a data position (3..21, not a power of two): flip that data bit, code 01.
  - q==1, s in 22..31: uncorrectable; output raw data bits, code 10.
  - s!=0, q==0: double error; output raw data bits uncorrected, code 10.
- Stored codewords are never scrubbed; a read does not write back corrected data.
- Address range is the full 0..255; there is no out-of-range case.
- Implementation: flip-flop array (not inferred RAM), required by the reset clear.

Decomposition:
- Package tbec_pkg:
  - ADDR_W, DATA_W, CW_W constants
  - typedef enum logic[1:0] tbec_err_e {ERR_NONE=0, ERR_DATA_CORR=1, ERR_UNCORR=2, ERR_CHK_CORR=3}
  - data-position lookup constant (d_i -> codeword position)
  - encode function
- One sub-module: tbec_secded_dec. Purely combinational, 22-bit codeword in, 16-bit data plus tbec_err_e out.
- Top holds the array, write encoding, injection XOR and output registers.

Test Plan:
1. Write 16'hE1F0 to 0x01 (mem_we high for 2 cycles), then read 0x01 -> data_out=16'hE1F0, out_error_code=00 one cycle after the read address is sampled; holds for repeated reads.
2. Write 16'hE1F0 to 0x01 with mask bit 3 set (d0), read -> 16'hE1F0, code 01. Repeat with mask bit 21 (d15) -> 16'hE1F0, code 01.
3. Write 16'hE1F0 to 0x01 with mask bit 0, then separately with mask bit 8 -> 16'hE1F0, code 11 in both cases.
4. Write 16'hE1F0 to 0x01 with mask bits 3 and 5 -> code 10, data_out = 16'hE1F0 with d0 and d1 flipped (16'hE1F3).
5. Write 16'hBBCC to 0x02 and 16'hFFA0 to 0x07, then read 0x07, 0x02, 0x01 back-to-back -> 16'hFFA0, 16'hBBCC, 16'hE1F0, each one cycle after its address, all code 00.
6. After writes, assert rst for one cycle (including while mem_we=1) -> data_out=16'h0000, code 00; subsequent read of 0x01 -> 16'h0000, code 00; the write during reset is ignored.

Source files
------------

// File: rtl/tbec_pkg.sv
// Shared constants, error status encoding and the SEC-DED encoder for the
// 256x16 protected storage array.
package tbec_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int CW_W   = 22;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_DATA_CORR = 2'd1,
    ERR_UNCORR    = 2'd2,
    ERR_CHK_CORR  = 2'd3
  } tbec_err_e;

  // Codeword position of data bit d_i; element 0 is the least significant.
  localparam logic [DATA_W-1:0][4:0] DATA_POS = {
    5'd21, 5'd20, 5'd19, 5'd18, 5'd17, 5'd15, 5'd14, 5'd13,
    5'd12, 5'd11, 5'd10, 5'd9,  5'd7,  5'd6,  5'd5,  5'd3
  };

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0] cw;
    logic            p;
    cw = '0;
    for (int i = 0; i < DATA_W; i++) begin
      cw[DATA_POS[i]] = data[i];
    end
    // Parity positions have a single index bit set, so p_k never covers another parity bit.
    for (int k = 0; k < 5; k++) begin
      p = 1'b0;
      for (int j = 1; j < CW_W; j++) begin
        if (j[k]) p = p ^ cw[j];
      end
      cw[1 << k] = p;
    end
    cw[0] = ^cw[CW_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/tbec_secded_dec.sv
// Combinational extended-Hamming decoder: corrects single errors, flags
// double errors and reports which kind of bit was in error.
module tbec_secded_dec
  import tbec_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output tbec_err_e         err
);

  logic [4:0]        syndrome;
  logic              overall;
  logic [DATA_W-1:0] raw;
  logic              is_pow2;

  always_comb begin
    syndrome = '0;
    overall  = ^cw;
    raw      = '0;
    for (int j = 1; j < CW_W; j++) begin
      if (cw[j]) syndrome = syndrome ^ 5'(j);
    end
    for (int i = 0; i < DATA_W; i++) begin
      raw[i] = cw[DATA_POS[i]];
    end
    is_pow2 = (syndrome != 5'd0) && ((syndrome & (syndrome - 5'd1)) == 5'd0);

    data = raw;
    err  = ERR_NONE;
    // Odd overall parity means an odd number of flips; treat as single unless the syndrome is impossible.
    if (!overall) begin
      if (syndrome != 5'd0) err = ERR_UNCORR;
    end else if (syndrome == 5'd0 || is_pow2) begin
      err = ERR_CHK_CORR;
    end else if (syndrome > 5'd21) begin
      err = ERR_UNCORR;
    end else begin
      err = ERR_DATA_CORR;
      for (int i = 0; i < DATA_W; i++) begin
        if (DATA_POS[i] == syndrome) data[i] = ~raw[i];
      end
    end
  end

endmodule

// File: rtl/tbec_ecc_mem.sv
// 256x16 SEC-DED protected flip-flop array with write-side error injection
// and a one-cycle registered, corrected read path.
module tbec_ecc_mem
  import tbec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] tbec_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_we,
  input  logic [CW_W-1:0]   err_inject_mask,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        out_error_code
);

  logic [CW_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0] dec_data;
  tbec_err_e         dec_err;

  tbec_secded_dec u_dec (
    .cw   (mem[tbec_addr]),
    .data (dec_data),
    .err  (dec_err)
  );

  // All-zero is the valid codeword for 16'h0000, so reset leaves a clean array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[tbec_addr] <= encode(data_in) ^ err_inject_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out       <= '0;
      out_error_code <= ERR_NONE;
    end else if (!mem_we) begin
      data_out       <= dec_data;
      out_error_code <= dec_err;
    end
  end

endmodule

// File: tb/tb_tbec_ecc_mem.sv
// Directed self-checking bench for tbec_ecc_mem: clean reads, injected
// single/double/triple errors, back-to-back reads and reset clearing.
module tb_tbec_ecc_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tbec_addr;
  logic [15:0] data_in;
  logic        mem_we;
  logic [21:0] err_inject_mask;
  logic [15:0] data_out;
  logic [1:0]  out_error_code;

  int checkCount = 0;
  int passCount  = 0;

  tbec_ecc_mem dut (
    .clk             (clk),
    .rst             (rst),
    .tbec_addr       (tbec_addr),
    .data_in         (data_in),
    .mem_we          (mem_we),
    .err_inject_mask (err_inject_mask),
    .data_out        (data_out),
    .out_error_code  (out_error_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Drive one cycle of inputs, clock it, and leave outputs settled 1ns after the edge.
  task automatic applyStimulus(input logic r, input logic we, input logic [7:0] a,
                               input logic [15:0] d, input logic [21:0] m);
    rst             = r;
    mem_we          = we;
    tbec_addr       = a;
    data_in         = d;
    err_inject_mask = m;
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [7:0] a, input logic [15:0] d, input logic [21:0] m);
    applyStimulus(1'b0, 1'b1, a, d, m);
  endtask

  task automatic readCheck(input string tag, input logic [7:0] a,
                           input logic [15:0] expData, input logic [1:0] expCode);
    applyStimulus(1'b0, 1'b0, a, 16'h0, 22'h0);
    checkOutput({tag, "_data"}, {16'h0, data_out}, {16'h0, expData});
    checkOutput({tag, "_code"}, {30'h0, out_error_code}, {30'h0, expCode});
  endtask

  initial begin
    rst = 1'b1; mem_we = 1'b0; tbec_addr = '0; data_in = '0; err_inject_mask = '0;
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 22'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 16'h0, 22'h0);
    checkOutput("reset_data", {16'h0, data_out}, 32'h0);
    checkOutput("reset_code", {30'h0, out_error_code}, 32'h0);

    // Clean write held two cycles, then repeated reads.
    writeWord(8'h01, 16'hE1F0, 22'h0);
    writeWord(8'h01, 16'hE1F0, 22'h0);
    readCheck("clean_rd1", 8'h01, 16'hE1F0, 2'b00);
    readCheck("clean_rd2", 8'h01, 16'hE1F0, 2'b00);

    // Output holds across a write cycle.
    writeWord(8'h05, 16'h1234, 22'h0);
    checkOutput("hold_on_write", {16'h0, data_out}, 32'h0000E1F0);

    // Single data-bit errors at both ends of the data field.
    writeWord(8'h01, 16'hE1F0, 22'h000008);
    readCheck("d0_flip", 8'h01, 16'hE1F0, 2'b01);
    writeWord(8'h01, 16'hE1F0, 22'h200000);
    readCheck("d15_flip", 8'h01, 16'hE1F0, 2'b01);

    // Check-bit errors: overall parity and each Hamming parity position.
    writeWord(8'h01, 16'hE1F0, 22'h000001);
    readCheck("p_all_flip", 8'h01, 16'hE1F0, 2'b11);
    writeWord(8'h01, 16'hE1F0, 22'h000100);
    readCheck("p3_flip", 8'h01, 16'hE1F0, 2'b11);
    writeWord(8'h01, 16'hE1F0, 22'h000002);
    readCheck("p0_flip", 8'h01, 16'hE1F0, 2'b11);
    writeWord(8'h01, 16'hE1F0, 22'h010000);
    readCheck("p4_flip", 8'h01, 16'hE1F0, 2'b11);

    // Double errors report raw data.
    writeWord(8'h01, 16'hE1F0, 22'h000028);
    readCheck("dbl_d0d1", 8'h01, 16'hE1F3, 2'b10);
    writeWord(8'h01, 16'hE1F0, 22'h200001);
    readCheck("dbl_d15_pall", 8'h01, 16'h61F0, 2'b10);

    // Three check-bit flips give syndrome 22: odd parity but impossible position.
    writeWord(8'h01, 16'hE1F0, 22'h010014);
    readCheck("syn22", 8'h01, 16'hE1F0, 2'b10);

    // Back-to-back reads, one per cycle.
    writeWord(8'h01, 16'hE1F0, 22'h0);
    writeWord(8'h02, 16'hBBCC, 22'h0);
    writeWord(8'h07, 16'hFFA0, 22'h0);
    readCheck("b2b_07", 8'h07, 16'hFFA0, 2'b00);
    readCheck("b2b_02", 8'h02, 16'hBBCC, 2'b00);
    readCheck("b2b_01", 8'h01, 16'hE1F0, 2'b00);
    writeWord(8'hFF, 16'h8001, 22'h0);
    readCheck("top_addr", 8'hFF, 16'h8001, 2'b00);

    // Reset with a write pending: write is dropped and the array is cleared.
    applyStimulus(1'b1, 1'b1, 8'h01, 16'hABCD, 22'h0);
    checkOutput("rst_we_data", {16'h0, data_out}, 32'h0);
    checkOutput("rst_we_code", {30'h0, out_error_code}, 32'h0);
    readCheck("post_rst_01", 8'h01, 16'h0000, 2'b00);
    readCheck("post_rst_07", 8'h07, 16'h0000, 2'b00);
    readCheck("post_rst_ff", 8'hFF, 16'h0000, 2'b00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
